ag6502_seq_alu: RTL and testbench
=================================

Name: ag6502_seq_alu

Overview:
- Parametrised, multi-cycle successor to the 6502 8-bit ALU. Operand width is WIDTH bits, a multiple of 4.
- ADC and SBC run nibble-serially, one nibble per clock, with optional NMOS-style decimal correction per nibble. Logic and shift operations finish in one cycle.
- Start/busy/done handshake. Intended for the wide-arithmetic coprocessor path beside the ag6502 core.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be ≥4 and a multiple of 4. NIB = WIDTH/4.
- DECIMAL_EN, 1, when 0 the d_in input is ignored and arithmetic is always binary.

Ports:
- phi_0  input  1  clock; every register updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Accepted only in IDLE or DONE.
- op  input  4  operation code; values come from the shared package.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in (for SBC, 1 means no borrow).
- d_in  input  1  decimal mode select.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
- r  output  WIDTH  result.
- c_out  output  1  carry flag.
- v_out  output  1  overflow flag.
- z_out  output  1  zero flag, r==0.
- n_out  output  1  negative flag, r[WIDTH-1].

Behaviour:
- Interface: one clock (phi_0), synchronous active-high reset rst.
- Reset: state=IDLE; busy, done, r, c_out, v_out, z_out and n_out are all 0. rst overrides start in the same cycle. rst mid-operation aborts to IDLE with no done pulse.
- States:
  - IDLE → RUN on start.
  - RUN → DONE once the last nibble has been processed.
  - DONE lasts one cycle (done=1), then returns to IDLE. A start seen in DONE goes straight to RUN (back-to-back).
- Start accept (cycle 0): latch a, the effective B operand (b, or ~b for SBC), c_in, d_eff = d_in & DECIMAL_EN, and op. Nibble index k=0. Set busy=1.
- Logic/shift ops (ORA AND EOR ASL LSR ROL ROR): result is computed in cycle 1; done=1 in cycle 1; busy deasserts in cycle 1. Latency 1.
- ADC/SBC: nibble k is processed in cycle k+1, k=0..NIB-1, with carry chained in a register. r, c_out, v_out, z_out and n_out are all updated in cycle NIB+1, together with done=1. Latency NIB+1. busy=1 during cycles 1..NIB.
- Start while busy (RUN) is ignored with no side effect. Outputs hold their last values until the next accepted operation completes.
- Nibble step: s = {0,a_k} + {0,bb_k} + cy, 5 bits.
  - Binary: result nibble = s[3:0], carry = s[4].
  - Decimal add: C9 = ({s[4],s[3:0]} > 9). Result nibble = C9 ? s[3:0]+6 : s[3:0] (mod 16). Carry = C9.
  - Decimal SBC: C9 = ({~s[4],s[3:0]} > 9). Result nibble = C9 ? s[3:0]+10 : s[3:0] (mod 16). Carry = ~C9.
- Shifts, whole word:
  - ASL: r={a[W-2:0],0}, C=a[W-1].
  - LSR: r={0,a[W-1:1]}, C=a[0].
  - ROL: r={a[W-2:0],c_in}, C=a[W-1].
  - ROR: r={c_in,a[W-1:1]}, C=a[0].
  - Logic ops leave c_out = c_in.
- Flags:
  - V = (a[W-1]==bb[W-1]) && (a[W-1]!=r[W-1]), using the corrected r. Updated only for ADC/SBC; otherwise 0.
  - Z and N come from the final r for every op.
- Undefined op codes: treated as ORA.

Decomposition:
- Package ag6502_pkg holds the op codes: ORA=0, AND=1, EOR=2, ADC=3, ASL=4, LSR=5, ROL=6, ROR=7, SBC=8. It also holds the FSM state encoding IDLE/RUN/DONE.
- One sub-module, ag6502_nibble_adder:
  - Inputs a[3:0], b[3:0], cin, dec, neg.
  - Outputs sum[3:0], cout.
  - Purely combinational, implementing the nibble step rule.
- Top-level holds the FSM, operand shift registers, nibble counter ($clog2(NIB)+1 bits) and the flag logic.

Test Plan:
- WIDTH=8, ADC, a=0x58, b=0x46, c_in=0, d_in=1 → cycle 3: done=1, r=0x04, c_out=1, z_out=0.
- WIDTH=8, SBC, a=0x12, b=0x21, c_in=1, d_in=1 → r=0x91, c_out=0, n_out=1.
- WIDTH=16, ADC binary, a=0x7FFF, b=0x0001, c_in=0 → done in cycle 5, r=0x8000, v_out=1, n_out=1, c_out=0. Also: start pulsed in cycle 2 is ignored.
- WIDTH=16, ROR, a=0x0001, c_in=1 → cycle 1: done=1, r=0x8000, c_out=1. A start in that DONE cycle (ADC 0xFFFF+0x0001) → r=0x0000, z_out=1, c_out=1 in cycle 6.
- DECIMAL_EN=0, ADC 0x09+0x01 with d_in=1 → r=0x0A (binary).
- Reset: rst in cycle 2 of a WIDTH=16 ADC → IDLE next cycle, busy=0, no done pulse, all outputs 0. start together with rst → ignored.

Source files
------------

// File: rtl/ag6502_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the ag6502
// wide-arithmetic ALU.
package ag6502_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ORA = 4'd0,
    OP_AND = 4'd1,
    OP_EOR = 4'd2,
    OP_ADC = 4'd3,
    OP_ASL = 4'd4,
    OP_LSR = 4'd5,
    OP_ROL = 4'd6,
    OP_ROR = 4'd7,
    OP_SBC = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ADC and SBC take the nibble-serial path; every other code is single-cycle
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/ag6502_seq_alu_if.sv
// Request/response bundle between a client and the sequential ALU.
interface ag6502_seq_alu_if #(
  parameter int unsigned WIDTH = 8
);

  logic                          start;
  logic [ag6502_pkg::OP_W-1:0]   op;
  logic [WIDTH-1:0]              a;
  logic [WIDTH-1:0]              b;
  logic                          c_in;
  logic                          d_in;
  logic                          busy;
  logic                          done;
  logic [WIDTH-1:0]              r;
  logic                          c_out;
  logic                          v_out;
  logic                          z_out;
  logic                          n_out;

  modport master (
    output start, op, a, b, c_in, d_in,
    input  busy, done, r, c_out, v_out, z_out, n_out
  );

  modport slave (
    input  start, op, a, b, c_in, d_in,
    output busy, done, r, c_out, v_out, z_out, n_out
  );

endinterface

// File: rtl/ag6502_nibble_adder.sv
// One 4-bit add step with optional NMOS-style decimal correction.
// neg selects the subtract correction (b is already inverted by the caller).
module ag6502_nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       dec,
  input  logic       neg,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] s;
  logic       c9;

  assign s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

  always_comb begin
    c9   = 1'b0;
    sum  = s[3:0];
    cout = s[4];
    if (dec) begin
      if (neg) begin
        // borrow view of the raw sum: ~carry acts as the tens digit
        c9   = ({~s[4], s[3:0]} > 5'd9);
        sum  = c9 ? (s[3:0] + 4'd10) : s[3:0];
        cout = ~c9;
      end else begin
        c9   = (s > 5'd9);
        sum  = c9 ? (s[3:0] + 4'd6) : s[3:0];
        cout = c9;
      end
    end
  end

endmodule

// File: rtl/ag6502_seq_alu.sv
// Multi-cycle 6502-style ALU: nibble-serial ADC/SBC with decimal correction,
// single-cycle logic and shift ops, start/busy/done handshake.
module ag6502_seq_alu
  import ag6502_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          DECIMAL_EN = 1'b1
) (
  input logic               phi_0,
  input logic               rst,
  ag6502_seq_alu_if.slave   bus
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = $clog2(NIB) + 1;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [OP_W-1:0]    op_q;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   acc;
  logic               cy;
  logic               cin_q;
  logic               dec_q;
  logic               neg_q;
  logic               a_msb;
  logic               b_msb;

  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   r_q;
  logic               c_q;
  logic               v_q;
  logic               z_q;
  logic               n_q;

  logic [WIDTH-1:0]   b_eff;
  logic [3:0]         nib_sum;
  logic               nib_cout;
  logic [WIDTH-1:0]   logic_r;
  logic               logic_c;

  assign b_eff = (bus.op == OP_SBC) ? ~bus.b : bus.b;

  ag6502_nibble_adder u_nib (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (cy),
    .dec  (dec_q),
    .neg  (neg_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Single-cycle ops; unknown codes fall back to ORA
  always_comb begin
    logic_r = a_sh | b_sh;
    logic_c = cin_q;
    case (op_q)
      OP_AND: logic_r = a_sh & b_sh;
      OP_EOR: logic_r = a_sh ^ b_sh;
      OP_ASL: begin
        logic_r = {a_sh[WIDTH-2:0], 1'b0};
        logic_c = a_sh[WIDTH-1];
      end
      OP_LSR: begin
        logic_r = {1'b0, a_sh[WIDTH-1:1]};
        logic_c = a_sh[0];
      end
      OP_ROL: begin
        logic_r = {a_sh[WIDTH-2:0], cin_q};
        logic_c = a_sh[WIDTH-1];
      end
      OP_ROR: begin
        logic_r = {cin_q, a_sh[WIDTH-1:1]};
        logic_c = a_sh[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge phi_0) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cy     <= 1'b0;
      cin_q  <= 1'b0;
      dec_q  <= 1'b0;
      neg_q  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      r_q    <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= b_eff;
            acc    <= '0;
            cy     <= bus.c_in;
            cin_q  <= bus.c_in;
            dec_q  <= bus.d_in & DECIMAL_EN;
            neg_q  <= (bus.op == OP_SBC);
            op_q   <= bus.op;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= b_eff[WIDTH-1];
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!is_arith(op_q)) begin
            r_q    <= logic_r;
            c_q    <= logic_c;
            v_q    <= 1'b0;
            z_q    <= (logic_r == '0);
            n_q    <= logic_r[WIDTH-1];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else if (cnt == CNT_W'(NIB)) begin
            // all nibbles in; publish word and flags together
            r_q    <= acc;
            c_q    <= cy;
            v_q    <= (a_msb == b_msb) && (a_msb != acc[WIDTH-1]);
            z_q    <= (acc == '0);
            n_q    <= acc[WIDTH-1];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            // result nibbles enter at the top and settle LSB-first
            acc  <= WIDTH'({nib_sum, acc} >> 4);
            a_sh <= a_sh >> 4;
            b_sh <= b_sh >> 4;
            cy   <= nib_cout;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.r     = r_q;
  assign bus.c_out = c_q;
  assign bus.v_out = v_q;
  assign bus.z_out = z_q;
  assign bus.n_out = n_q;

endmodule

// File: tb/tb_ag6502_seq_alu.sv
// Self-checking bench: directed table, handshake corner sequences and random
// ops against an arithmetic reference model, across three ALU configurations.
module tb_ag6502_seq_alu;
  import ag6502_pkg::*;

  logic phi_0;
  logic rst;

  // sel 0: W=8 decimal, sel 1: W=16 decimal, sel 2: W=8 decimal disabled
  ag6502_seq_alu_if #(.WIDTH(8))  if8  ();
  ag6502_seq_alu_if #(.WIDTH(16)) if16 ();
  ag6502_seq_alu_if #(.WIDTH(8))  if8n ();

  ag6502_seq_alu #(.WIDTH(8),  .DECIMAL_EN(1'b1)) dut8  (.phi_0(phi_0), .rst(rst), .bus(if8));
  ag6502_seq_alu #(.WIDTH(16), .DECIMAL_EN(1'b1)) dut16 (.phi_0(phi_0), .rst(rst), .bus(if16));
  ag6502_seq_alu #(.WIDTH(8),  .DECIMAL_EN(1'b0)) dut8n (.phi_0(phi_0), .rst(rst), .bus(if8n));

  initial phi_0 = 1'b0;
  always #5 phi_0 = ~phi_0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } obs_t;

  typedef struct {
    int          sel;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        d;
    logic [15:0] r;
    logic        co;
    logic        vo;
    logic        zo;
    logic        no;
    int          lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mkv(input int sel, input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic c, input logic d,
                               input logic [15:0] r, input logic co, input logic vo,
                               input logic zo, input logic no, input int lat);
    vec_t v;
    v.sel = sel; v.op = op; v.a = a; v.b = b; v.c = c; v.d = d;
    v.r = r; v.co = co; v.vo = vo; v.zo = zo; v.no = no; v.lat = lat;
    return v;
  endfunction

  // Reference: whole-word arithmetic for binary, digit-by-digit rule for decimal
  function automatic vec_t model(input int sel, input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic c, input logic d);
    vec_t e;
    int unsigned w, mask, ua, ub, bb, res, s, cy, an, bn, rn, hi, cf;
    logic de, c9;
    w    = (sel == 1) ? 16 : 8;
    mask = (32'd1 << w) - 32'd1;
    ua   = 32'(a) & mask;
    ub   = 32'(b) & mask;
    de   = d && (sel != 2);
    cf   = 32'(c);
    res  = 0;
    e = mkv(sel, op, 16'(ua), 16'(ub), c, d, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    case (op)
      OP_ADC, OP_SBC: begin
        bb    = (op == OP_SBC) ? (~ub & mask) : ub;
        e.lat = int'(w / 4) + 1;
        if (!de) begin
          s   = ua + bb + 32'(c);
          res = s & mask;
          cf  = (s >> w) & 32'd1;
        end else begin
          cy = 32'(c);
          for (int k = 0; k < int'(w / 4); k++) begin
            an = (ua >> (4 * k)) & 32'd15;
            bn = (bb >> (4 * k)) & 32'd15;
            s  = an + bn + cy;
            if (op == OP_ADC) begin
              c9 = (s > 9);
              rn = c9 ? ((s + 6) & 32'd15) : (s & 32'd15);
              cy = 32'(c9);
            end else begin
              hi = (s >= 16) ? 32'd0 : 32'd16;
              c9 = ((hi + (s & 32'd15)) > 9);
              rn = c9 ? ((s + 10) & 32'd15) : (s & 32'd15);
              cy = 32'(!c9);
            end
            res = res | (rn << (4 * k));
          end
          cf = cy;
        end
        e.vo = (ua[w-1] == bb[w-1]) && (ua[w-1] != res[w-1]);
      end
      OP_ASL: begin res = (ua << 1) & mask;            cf = 32'(ua[w-1]); end
      OP_LSR: begin res = ua >> 1;                     cf = 32'(ua[0]);   end
      OP_ROL: begin res = ((ua << 1) | 32'(c)) & mask; cf = 32'(ua[w-1]); end
      OP_ROR: begin res = (ua >> 1) | (32'(c) << (w - 1)); cf = 32'(ua[0]); end
      OP_AND: res = ua & ub;
      OP_EOR: res = ua ^ ub;
      default: res = ua | ub;
    endcase
    e.r  = 16'(res);
    e.co = cf[0];
    e.zo = (res == 0);
    e.no = res[w-1];
    return e;
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic c, input logic d);
    case (sel)
      0: begin if8.start = st;  if8.op = op;  if8.a = a[7:0];  if8.b = b[7:0];  if8.c_in = c;  if8.d_in = d;  end
      1: begin if16.start = st; if16.op = op; if16.a = a;      if16.b = b;      if16.c_in = c; if16.d_in = d; end
      default: begin if8n.start = st; if8n.op = op; if8n.a = a[7:0]; if8n.b = b[7:0]; if8n.c_in = c; if8n.d_in = d; end
    endcase
  endtask

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    case (sel)
      0: begin o.busy = if8.busy;  o.done = if8.done;  o.r = 16'(if8.r);  o.c = if8.c_out;  o.v = if8.v_out;  o.z = if8.z_out;  o.n = if8.n_out;  end
      1: begin o.busy = if16.busy; o.done = if16.done; o.r = if16.r;      o.c = if16.c_out; o.v = if16.v_out; o.z = if16.z_out; o.n = if16.n_out; end
      default: begin o.busy = if8n.busy; o.done = if8n.done; o.r = 16'(if8n.r); o.c = if8n.c_out; o.v = if8n.v_out; o.z = if8n.z_out; o.n = if8n.n_out; end
    endcase
    return o;
  endfunction

  function automatic logic [31:0] exp_word(input vec_t e);
    obs_t o;
    o.busy = 1'b0; o.done = 1'b1; o.r = e.r; o.c = e.co; o.v = e.vo; o.z = e.zo; o.n = e.no;
    return 32'(o);
  endfunction

  // Called at the negedge just after the accept edge; counts cycles to done
  task automatic wait_done(input int sel, output obs_t o, output int lat);
    lat = -1;
    o   = get_obs(sel);
    for (int i = 1; i <= 32 && lat < 0; i++) begin
      @(negedge phi_0);
      o = get_obs(sel);
      if (o.done) lat = i;
    end
  endtask

  task automatic do_op(input int sel, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic c, input logic d,
                       output obs_t o, output int lat);
    @(negedge phi_0);
    set_in(sel, 1'b1, op, a, b, c, d);
    @(posedge phi_0);
    @(negedge phi_0);
    set_in(sel, 1'b0, op, a, b, c, d);
    wait_done(sel, o, lat);
  endtask

  vec_t vt[14];
  vec_t e;
  obs_t o;
  int   lat;
  logic seen;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = mkv(0, OP_ADC, 16'h0058, 16'h0046, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    vt[1]  = mkv(0, OP_SBC, 16'h0012, 16'h0021, 1'b1, 1'b1, 16'h0091, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    vt[2]  = mkv(1, OP_ADC, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 5);
    vt[3]  = mkv(1, OP_ROR, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    vt[4]  = mkv(2, OP_ADC, 16'h0009, 16'h0001, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    vt[5]  = mkv(1, OP_ADC, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 5);
    vt[6]  = mkv(0, OP_ASL, 16'h0081, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    vt[7]  = mkv(0, OP_LSR, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    vt[8]  = mkv(0, OP_ROL, 16'h0080, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    vt[9]  = mkv(0, OP_AND, 16'h00F0, 16'h003C, 1'b1, 1'b0, 16'h0030, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    vt[10] = mkv(0, OP_EOR, 16'h00FF, 16'h000F, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    vt[11] = mkv(0, 4'd12,  16'h0010, 16'h0001, 1'b1, 1'b0, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    vt[12] = mkv(0, OP_ADC, 16'h0099, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    vt[13] = mkv(2, OP_SBC, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b1, 3);

    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset with a concurrent start: start must be ignored, outputs cleared
    rst = 1'b1;
    set_in(1, 1'b1, OP_ADC, 16'h1234, 16'h1111, 1'b0, 1'b0);
    repeat (3) @(negedge phi_0);
    for (int s = 0; s < 3; s++) begin
      o = get_obs(s);
      chk($sformatf("reset_state_sel%0d", s), 32'(o), 32'h0);
    end
    rst = 1'b0;
    set_in(1, 1'b0, OP_ADC, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge phi_0);
    o = get_obs(1);
    chk("start_with_rst_ignored", {30'h0, o.busy, o.done}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      do_op(vt[i].sel, vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].d, o, lat);
      chk($sformatf("vec%0d_result", i), 32'(o), exp_word(vt[i]));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    end

    // Start pulsed while running must not disturb the op in flight
    @(negedge phi_0);
    set_in(1, 1'b1, OP_ADC, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(posedge phi_0);
    @(negedge phi_0);
    set_in(1, 1'b0, OP_ADC, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge phi_0);
      set_in(1, (i == 1), OP_ASL, 16'h0000, 16'h0000, 1'b0, 1'b0);
      o = get_obs(1);
      if (o.done) lat = i;
    end
    chk("busy_ignore_latency", 32'(lat), 32'd5);
    chk("busy_ignore_result", 32'(o), exp_word(vt[2]));
    seen = 1'b0;
    repeat (4) begin
      @(negedge phi_0);
      o = get_obs(1);
      if (o.busy || o.done) seen = 1'b1;
    end
    chk("busy_ignore_no_second_op", 32'(seen), 32'h0);

    // Back-to-back: new start accepted in the DONE cycle
    do_op(1, OP_ROR, 16'h0001, 16'h0000, 1'b1, 1'b0, o, lat);
    chk("b2b_ror_result", 32'(o), exp_word(vt[3]));
    set_in(1, 1'b1, OP_ADC, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge phi_0);
    @(negedge phi_0);
    set_in(1, 1'b0, OP_ADC, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    o = get_obs(1);
    chk("b2b_accept_busy_done", {30'h0, o.busy, o.done}, 32'h2);
    wait_done(1, o, lat);
    chk("b2b_adc_latency", 32'(lat), 32'd5);
    chk("b2b_adc_result", 32'(o), exp_word(vt[5]));

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [3:0] op;
      logic [15:0] ra, rb;
      logic rc, rd;
      sel = int'($urandom_range(0, 2));
      op  = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      rd  = 1'($urandom);
      e   = model(sel, op, ra, rb, rc, rd);
      do_op(sel, op, e.a, e.b, rc, rd, o, lat);
      chk($sformatf("rand%0d_sel%0d_op%0d_a%h_b%h_result", i, sel, op, e.a, e.b), 32'(o), exp_word(e));
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(e.lat));
    end

    // Reset mid-operation aborts with no done pulse and clears outputs
    @(negedge phi_0);
    set_in(1, 1'b1, OP_ADC, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(posedge phi_0);
    @(negedge phi_0);
    set_in(1, 1'b0, OP_ADC, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(negedge phi_0);
    rst = 1'b1;
    set_in(1, 1'b1, OP_ADC, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(negedge phi_0);
    o = get_obs(1);
    chk("rst_mid_outputs", 32'(o), 32'h0);
    rst = 1'b0;
    set_in(1, 1'b0, OP_ADC, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge phi_0);
      o = get_obs(1);
      if (o.busy || o.done) seen = 1'b1;
    end
    chk("rst_mid_no_done", 32'(seen), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
